// File: rtl/sqrt_u32_pkg.sv
// Shared widths and the per-stage pipeline record for the integer square root.
package sqrt_u32_pkg;

  localparam int IN_W   = 32;
  localparam int OUT_W  = 16;
  localparam int STAGES = 16;
  localparam int REM_W  = 18;

  // Everything one pipeline stage hands to the next.
  typedef struct packed {
    logic             vld;
    logic [REM_W-1:0] rem;
    logic [OUT_W-1:0] root;
    logic [IN_W-1:0]  rad;
  } stage_t;

endpackage

// File: rtl/sqrt_u32_stage.sv
// One radix-2 restoring square-root step: resolves one result bit, MSB first.
module sqrt_u32_stage
  import sqrt_u32_pkg::*;
#(
  parameter int IDX = 0
) (
  input  logic   clk,
  input  logic   rst,
  input  stage_t stage_i,
  output stage_t stage_o
);

  // Radicand bit pair consumed by this stage.
  localparam int HI = IN_W - 1 - 2 * IDX;

  stage_t           stage_d;
  stage_t           stage_q;
  logic [REM_W+1:0] acc;
  logic [REM_W+1:0] sub;
  logic [REM_W+1:0] trial;
  logic             neg;
  logic             unused_hi;

  // Trial subtract of (root<<2 | 1) from (rem<<2 | next pair); keep it only when non-negative.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    stage_d      = stage_i;
    acc          = {stage_i.rem, stage_i.rad[HI -: 2]};
    sub          = {2'b00, stage_i.root, 2'b01};
    trial        = acc - sub;
    neg          = trial[REM_W+1];
    stage_d.rem  = neg ? acc[REM_W-1:0] : trial[REM_W-1:0];
    stage_d.root = {stage_i.root[OUT_W-2:0], ~neg};
  end

  // The remainder never exceeds REM_W bits, so these top bits carry no information.
  assign unused_hi = ^{acc[REM_W+1:REM_W], trial[REM_W]};

  // Stage register: advances every cycle, data included; reset clears all fields.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every stage samples the pre-edge value.
    if (rst) begin
      // NOTE: data fields are cleared too, so no stale partial result survives a reset.
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign stage_o = stage_q;

endmodule

// File: rtl/sqrt_u32.sv
// Fully pipelined floor(sqrt(x)) for 32-bit unsigned input; 16-cycle latency, one operand per clock.
module sqrt_u32
  import sqrt_u32_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_in,
  input  logic [IN_W-1:0]   x,
  output logic              vld_out,
  output logic [OUT_W-1:0]  y
);

  stage_t head;
  stage_t pipe [STAGES];
  logic   unused_tail;

  // Seed the pipeline: empty remainder and root, full radicand.
  always_comb begin
    head      = '0;
    head.vld  = vld_in;
    head.rad  = x;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      sqrt_u32_stage #(.IDX(k)) u_stage (
        .clk     (clk),
        .rst     (rst),
        .stage_i (head),
        .stage_o (pipe[k])
      );
    end else begin : g_rest
      sqrt_u32_stage #(.IDX(k)) u_stage (
        .clk     (clk),
        .rst     (rst),
        .stage_i (pipe[k-1]),
        .stage_o (pipe[k])
      );
    end
  end

  assign vld_out = pipe[STAGES-1].vld;
  assign y       = pipe[STAGES-1].root;

  // Final remainder and radicand are not exported.
  assign unused_tail = ^{pipe[STAGES-1].rem, pipe[STAGES-1].rad};

endmodule

// File: tb/tb_sqrt_u32.sv
// Self-checking bench for sqrt_u32 against a 16-deep delay-line model of floor(sqrt(x)).
module tb_sqrt_u32;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld_in;
  logic [31:0] x;
  logic        vld_out;
  logic [15:0] y;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic        v;
    logic [31:0] x;
    logic [15:0] y;
  } exp_t;

  exp_t model_q[$];
  bit   range_chk = 0;
  bit   lat_armed = 0;
  int   first_cyc = 0;

  sqrt_u32 dut (
    .clk     (clk),
    .rst     (rst),
    .vld_in  (vld_in),
    .x       (x),
    .vld_out (vld_out),
    .y       (y)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Largest r with r*r <= v, by binary search in 64-bit arithmetic.
  function automatic logic [15:0] isqrt(input logic [31:0] v);
    longint unsigned lo = 0;
    longint unsigned hi = 65536;
    longint unsigned mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= longint'(v)) lo = mid;
      else hi = mid;
    end
    return lo[15:0];
  endfunction

  // One clock: drive inputs, advance the model, then sample the DUT after the edge.
  task automatic tick(input logic r, input logic v, input logic [31:0] xv);
    exp_t            e;
    longint unsigned yy;
    longint unsigned xx;
    rst    = r;
    vld_in = v;
    x      = xv;
    @(posedge clk);
    cyc++;
    if (r) begin
      foreach (model_q[i]) begin
        model_q[i].v = 1'b0;
        model_q[i].x = '0;
        model_q[i].y = '0;
      end
    end else begin
      e.v = v;
      e.x = xv;
      e.y = isqrt(xv);
      model_q.push_back(e);
      void'(model_q.pop_front());
    end
    #1;
    e = model_q[0];
    check("vld_out", {63'd0, vld_out}, {63'd0, e.v});
    if (r) check("rst_y", {48'd0, y}, 64'd0);
    if (e.v) begin
      check("y", {48'd0, y}, {48'd0, e.y});
      if (range_chk) begin
        yy = longint'(y);
        xx = longint'(e.x);
        check("range_lo", {63'd0, (yy * yy <= xx)}, 64'd1);
        check("range_hi", {63'd0, (xx < (yy + 1) * (yy + 1))}, 64'd1);
      end
    end
    if (lat_armed && vld_out) begin
      check("latency", 64'(cyc - first_cyc), 64'd16);
      lat_armed = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, $urandom);
  endtask

  logic [31:0] directed [10] = '{32'd0, 32'd1, 32'd3, 32'd4, 32'd15, 32'd16,
                                 32'hFFFE0000, 32'hFFFE0001, 32'hFFFFFFFF, 32'h40000000};
  logic [15:0] directed_y [10] = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd3, 16'd4,
                                   16'hFFFE, 16'hFFFF, 16'hFFFF, 16'h8000};
  logic        bubble [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    for (int i = 0; i < 16; i++) model_q.push_back('{v: 1'b0, x: '0, y: '0});

    // Reset, then counting sweep with latency measured on the first valid.
    tick(1'b1, 1'b0, 32'd0);
    tick(1'b1, 1'b0, 32'd0);
    first_cyc = cyc;
    lat_armed = 1;
    for (int i = 0; i < 2000; i++) tick(1'b0, 1'b1, i);
    if (lat_armed) check("latency_timeout", 64'd1, 64'd0);
    lat_armed = 0;
    idle(16);

    // Directed boundary operands; the model is cross-checked against the known roots.
    for (int i = 0; i < 10; i++) begin
      check("model_ref", {48'd0, isqrt(directed[i])}, {48'd0, directed_y[i]});
      tick(1'b0, 1'b1, directed[i]);
    end
    idle(16);

    // Bubble pattern with distinct operands.
    for (int i = 0; i < 6; i++) tick(1'b0, bubble[i], 32'h1000_0000 + 32'(i) * 32'h0123_4567);
    idle(16);

    // Reset with eight operands in flight; then one fresh operand.
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, $urandom);
    tick(1'b1, 1'b0, 32'd0);
    idle(20);
    tick(1'b0, 1'b1, 32'd1_000_000);
    idle(16);

    // Reset and valid together: the operand must vanish.
    tick(1'b1, 1'b1, 32'd100);
    idle(20);

    // Random back-to-back stream.
    range_chk = 1;
    for (int i = 0; i < 10000; i++) tick(1'b0, 1'b1, $urandom);
    idle(16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
